// File: rtl/cpu_datapath_if.sv
// Control/status bundle between the accumulator-CPU controller (plus its
// instruction memory) and the datapath.
interface cpu_datapath_if;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       loadIR;
   logic       incPC;
   logic       loadPC;
   logic       selPC;
   logic       loadAcc;
   logic [1:0] selACC;
   logic       loadReg;
   logic [3:0] aluOp;
   logic       halt;
   logic [7:0] instr;
   logic       flagZ;
   logic       flagN;
   logic [7:0] acc_out;
   logic [7:0] pc_out;

   modport master (
      output imem_data, loadIR, incPC, loadPC, selPC, loadAcc, selACC,
             loadReg, aluOp, halt,
      input  imem_addr, instr, flagZ, flagN, acc_out, pc_out
   );

   modport slave (
      input  imem_data, loadIR, incPC, loadPC, selPC, loadAcc, selACC,
             loadReg, aluOp, halt,
      output imem_addr, instr, flagZ, flagN, acc_out, pc_out
   );
endinterface

// File: rtl/cpu_datapath.sv
// Datapath of the 8-bit accumulator CPU: PC, IR, ACC, 16x8 register file and
// ALU. Purely a responder; all sequencing comes from the controller.
module cpu_datapath #(
   parameter logic [7:0] PC_RESET = 8'h00,
   parameter int         RF_DEPTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   cpu_datapath_if.slave  bus
);

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0001,
      ALU_SUB = 4'b0010,
      ALU_NOR = 4'b0011,
      ALU_SHL = 4'b1011,
      ALU_SHR = 4'b1100
   } alu_op_e;

   logic [7:0] pc;
   logic [7:0] ir;
   logic [7:0] acc;
   logic [7:0] rf [RF_DEPTH];

   logic [3:0] opr;
   logic [7:0] rf_rd;
   logic [7:0] alu_y;
   logic [7:0] acc_src;
   logic [7:0] pc_tgt;

   assign opr   = ir[3:0];
   assign rf_rd = rf[opr];

   // NOTE: every combinational output gets a default first so no path
   // through the case statements can infer a latch.
   always_comb begin
      alu_y = acc;
      case (bus.aluOp)
         ALU_ADD: alu_y = rf_rd + acc;
         ALU_SUB: alu_y = rf_rd - acc;
         ALU_NOR: alu_y = ~(rf_rd | acc);
         ALU_SHL: alu_y = {acc[6:0], 1'b0};
         ALU_SHR: alu_y = {1'b0, acc[7:1]};
         default: alu_y = acc;
      endcase
   end

   always_comb begin
      acc_src = acc;
      case (bus.selACC)
         2'b00:   acc_src = alu_y;
         2'b01:   acc_src = rf_rd;
         2'b10:   acc_src = {4'b0000, opr};
         default: acc_src = acc;
      endcase
   end

   assign pc_tgt = bus.selPC ? {4'b0000, opr} : rf_rd;

   // NOTE: non-blocking assignments make every register sample pre-edge
   // values, which is what gives RF the old ACC and loadPC the old RF entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc  <= PC_RESET;
         ir  <= 8'h00;
         acc <= 8'h00;
      end else if (!bus.halt) begin
         if (bus.loadPC)
            pc <= pc_tgt;
         else if (bus.incPC)
            pc <= pc + 8'd1;
         if (bus.loadIR)
            ir <= bus.imem_data;
         if (bus.loadAcc)
            acc <= acc_src;
      end
   end

   // NOTE: the register file lives in flops and is cleared by reset, so it
   // cannot map onto a reset-less RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RF_DEPTH; i++)
            rf[i] <= 8'h00;
      end else if (!bus.halt && bus.loadReg) begin
         rf[opr] <= acc;
      end
   end

   assign bus.imem_addr = pc;
   assign bus.instr     = ir;
   assign bus.flagZ     = (acc == 8'h00);
   assign bus.flagN     = acc[7];
   assign bus.acc_out   = acc;
   assign bus.pc_out    = pc;

endmodule
